// File: rtl/exec_pkg.sv
// Shared execute-stage definitions: ALU op classes, R-type funct codes,
// ALU function selects and the multiply-divide sequencer state encoding.
package exec_pkg;

    // alu_op classes produced by the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    // R-type funct field values
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_EXT9  = 6'b101100;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    // ALU function selects
    localparam logic [3:0] AF_AND  = 4'b0000;
    localparam logic [3:0] AF_OR   = 4'b0001;
    localparam logic [3:0] AF_ADD  = 4'b0010;
    localparam logic [3:0] AF_SUBU = 4'b0011;
    localparam logic [3:0] AF_XOR  = 4'b0100;
    localparam logic [3:0] AF_SRAV = 4'b0101;
    localparam logic [3:0] AF_SUB  = 4'b0110;
    localparam logic [3:0] AF_SLT  = 4'b0111;
    localparam logic [3:0] AF_SRLV = 4'b1000;
    localparam logic [3:0] AF_EXT9 = 4'b1001;
    localparam logic [3:0] AF_MFHI = 4'b1010;
    localparam logic [3:0] AF_MFLO = 4'b1011;
    localparam logic [3:0] AF_NOP  = 4'b1111;

    // Multiply-divide sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // MULT/MULTU/DIV/DIVU all share the 0110xx funct pattern
    function automatic logic is_md_funct(input logic [5:0] f);
        return f[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/alu_func_decode.sv
// Pure combinational ALU control decode: alu_op/funct to ALU function select,
// plus classification of multiply-divide and HI/LO-read instructions.
module alu_func_decode
    import exec_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_function,
    output logic       is_md,
    output logic       is_hilo_rd
);

    logic is_rtype;

    assign is_rtype   = (alu_op == ALUOP_RTYPE);
    assign is_md      = is_rtype && is_md_funct(funct);
    assign is_hilo_rd = is_rtype && ((funct == F_MFHI) || (funct == F_MFLO));

    // Function select; mult/div and unknown functs leave the ALU on the no-op code
    always_comb begin
        alu_function = AF_NOP;
        case (alu_op)
            ALUOP_ADD: alu_function = AF_ADD;
            ALUOP_SUB: alu_function = AF_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    F_ADD:   alu_function = AF_ADD;
                    F_SUB:   alu_function = AF_SUB;
                    F_AND:   alu_function = AF_AND;
                    F_OR:    alu_function = AF_OR;
                    F_SUBU:  alu_function = AF_SUBU;
                    F_XOR:   alu_function = AF_XOR;
                    F_SLT:   alu_function = AF_SLT;
                    F_SRAV:  alu_function = AF_SRAV;
                    F_SRLV:  alu_function = AF_SRLV;
                    F_EXT9:  alu_function = AF_EXT9;
                    F_MFHI:  alu_function = AF_MFHI;
                    F_MFLO:  alu_function = AF_MFLO;
                    default: alu_function = AF_NOP;
                endcase
            end
            default: alu_function = AF_NOP;
        endcase
    end

endmodule

// File: rtl/exec_md_control.sv
// Execute-stage control: ALU decode plus an iterative multiply-divide
// sequencer that strobes the datapath, writes HI/LO and stalls HI/LO hazards.
module exec_md_control
    import exec_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    input  logic       div_zero,
    output logic [3:0] alu_function,
    output logic       md_start,
    output logic       md_div,
    output logic       md_signed,
    output logic       hilo_we,
    output logic       div_exc,
    output logic       stall,
    output logic       busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    // Counter preload: the op spends LAT cycles in BUSY, counting LAT-1 down to 0
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    md_state_e        state_reg;
    md_state_e        state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             md_div_reg;
    logic             md_signed_reg;
    logic             div_exc_reg;

    logic is_md;
    logic is_hilo_rd;
    logic idle;
    logic accept;
    logic div_reject;

    alu_func_decode u_decode (
        .alu_op       (alu_op),
        .funct        (funct),
        .alu_function (alu_function),
        .is_md        (is_md),
        .is_hilo_rd   (is_hilo_rd)
    );

    // funct[1] distinguishes divide from multiply within the 0110xx group
    assign idle       = (state_reg == ST_IDLE);
    assign accept     = idle && valid && is_md && !(funct[1] && div_zero);
    assign div_reject = idle && valid && is_md && funct[1] && div_zero;

    // Next-state, counter and strobe logic; reset suppresses both strobes
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        md_start   = 1'b0;
        hilo_we    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    md_start   = 1'b1;
                    state_next = ST_BUSY;
                    cnt_next   = funct[1] ? DIV_LOAD : MUL_LOAD;
                end
            end
            ST_BUSY: begin
                if (cnt_reg == '0) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_DONE: begin
                hilo_we    = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (reset) begin
            md_start = 1'b0;
            hilo_we  = 1'b0;
        end
    end

    // Sequencer state, counter, operation attributes and divide-exception pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            md_div_reg    <= 1'b0;
            md_signed_reg <= 1'b0;
            div_exc_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            div_exc_reg <= div_reject;
            if (accept) begin
                md_div_reg    <= funct[1];
                md_signed_reg <= ~funct[0];
            end
        end
    end

    assign md_div    = md_div_reg;
    assign md_signed = md_signed_reg;
    assign div_exc   = div_exc_reg;
    assign busy      = !idle;
    // Only instructions touching HI/LO wait; the accepting op itself sees IDLE
    assign stall     = valid && (is_md || is_hilo_rd) && !idle;

endmodule

// File: tb/tb_exec_md_control.sv
// Directed bench for exec_md_control: decode table and sweep, then
// hand-written multiply/divide timing, div-by-zero, reset-abort and hazard sequences.
module tb_exec_md_control;

    logic       clk;
    logic       rst;
    logic       valid;
    logic [1:0] alu_op;
    logic [5:0] funct;
    logic       div_zero;
    logic [3:0] alu_function;
    logic       md_start;
    logic       md_div;
    logic       md_signed;
    logic       hilo_we;
    logic       div_exc;
    logic       stall;
    logic       busy;

    int total;
    int bad;

    exec_md_control #(
        .MUL_LAT (4),
        .DIV_LAT (32)
    ) dut (
        .clk          (clk),
        .reset        (rst),
        .valid        (valid),
        .alu_op       (alu_op),
        .funct        (funct),
        .div_zero     (div_zero),
        .alu_function (alu_function),
        .md_start     (md_start),
        .md_div       (md_div),
        .md_signed    (md_signed),
        .hilo_we      (hilo_we),
        .div_exc      (div_exc),
        .stall        (stall),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [1:0] alu_op;
        logic [5:0] funct;
        logic [3:0] exp_func;
        logic       exp_stall;
        logic       exp_start;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs just after a rising edge
    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f, input logic dz);
        valid    = v;
        alu_op   = op;
        funct    = f;
        div_zero = dz;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Expected ALU select from the instruction table
    function automatic logic [3:0] ref_func(input logic [1:0] op, input logic [5:0] f);
        logic [3:0] r;
        r = 4'b1111;
        case (op)
            2'b00: r = 4'b0010;
            2'b01: r = 4'b0110;
            2'b10: begin
                case (f)
                    6'b100000: r = 4'b0010;
                    6'b100010: r = 4'b0110;
                    6'b100100: r = 4'b0000;
                    6'b100101: r = 4'b0001;
                    6'b100011: r = 4'b0011;
                    6'b100110: r = 4'b0100;
                    6'b101010: r = 4'b0111;
                    6'b000111: r = 4'b0101;
                    6'b000110: r = 4'b1000;
                    6'b101100: r = 4'b1001;
                    6'b010000: r = 4'b1010;
                    6'b010010: r = 4'b1011;
                    default:   r = 4'b1111;
                endcase
            end
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        vecs[0]  = '{1'b1, 2'b00, 6'b100010, 4'b0010, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'b01, 6'b000000, 4'b0110, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 2'b11, 6'b011000, 4'b1111, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 2'b00, 6'b011011, 4'b0010, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 2'b10, 6'b100000, 4'b0010, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 2'b10, 6'b100010, 4'b0110, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 2'b10, 6'b100100, 4'b0000, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 2'b10, 6'b100101, 4'b0001, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 2'b10, 6'b100011, 4'b0011, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 2'b10, 6'b100110, 4'b0100, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 2'b10, 6'b101010, 4'b0111, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 2'b10, 6'b000111, 4'b0101, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 2'b10, 6'b000110, 4'b1000, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 2'b10, 6'b101100, 4'b1001, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 2'b10, 6'b010000, 4'b1010, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 2'b10, 6'b010010, 4'b1011, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 2'b10, 6'b111111, 4'b1111, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 2'b10, 6'b011000, 4'b1111, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 2'b10, 6'b011011, 4'b1111, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 2'b10, 6'b000000, 4'b1111, 1'b0, 1'b0};

        // Reset cycle with a valid MULT presented: nothing may start
        rst = 1'b1;
        drive(1'b1, 2'b10, 6'b011000, 1'b0);
        #1;
        settle();
        chk("reset_md_start", 32'(md_start), 32'd0);
        next_cycle();
        drive(1'b0, 2'b00, 6'b000000, 1'b0);
        settle();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_md_div", 32'(md_div), 32'd0);
        chk("reset_md_signed", 32'(md_signed), 32'd0);
        chk("reset_div_exc", 32'(div_exc), 32'd0);
        chk("reset_hilo_we", 32'(hilo_we), 32'd0);
        next_cycle();
        rst = 1'b0;

        // Decode table
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].valid, vecs[i].alu_op, vecs[i].funct, 1'b0);
            settle();
            $display("vec %0d: valid=%0b op=%b funct=%b func=%b stall=%0b start=%0b",
                     i, vecs[i].valid, vecs[i].alu_op, vecs[i].funct, alu_function, stall, md_start);
            chk($sformatf("vec%0d_func", i), 32'(alu_function), 32'(vecs[i].exp_func));
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_start", i), 32'(md_start), 32'(vecs[i].exp_start));
            next_cycle();
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
        end

        // Full R-type funct sweep; mult/div functs presented with valid low
        for (int f = 0; f < 64; f++) begin
            logic [5:0] fv;
            fv = 6'(f);
            drive((fv[5:2] != 4'b0110), 2'b10, fv, 1'b0);
            settle();
            $display("sweep funct=%b func=%b", fv, alu_function);
            chk($sformatf("sweep%0d_func", f), 32'(alu_function), 32'(ref_func(2'b10, fv)));
            chk($sformatf("sweep%0d_start", f), 32'(md_start), 32'd0);
            chk($sformatf("sweep%0d_stall", f), 32'(stall), 32'd0);
            next_cycle();
        end

        // MULT: accept at T, BUSY T+1..T+4, DONE (hilo_we) at T+5
        drive(1'b1, 2'b10, 6'b011000, 1'b0);
        settle();
        $display("mult accept: start=%0b stall=%0b", md_start, stall);
        chk("mult_start", 32'(md_start), 32'd1);
        chk("mult_stall", 32'(stall), 32'd0);
        next_cycle();
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, 2'b00, 6'b000000, 1'b0);
            settle();
            $display("mult T+%0d: busy=%0b hilo_we=%0b", k, busy, hilo_we);
            chk($sformatf("mult_busy_T%0d", k), 32'(busy), 32'(k <= 5));
            chk($sformatf("mult_hilo_T%0d", k), 32'(hilo_we), 32'(k == 5));
            chk($sformatf("mult_start_T%0d", k), 32'(md_start), 32'd0);
            if (k == 1) begin
                chk("mult_md_div", 32'(md_div), 32'd0);
                chk("mult_md_signed", 32'(md_signed), 32'd1);
            end
            next_cycle();
        end

        // DIVU, ADD at T+1, MFLO from T+3 stalls through DONE at T+33
        drive(1'b1, 2'b10, 6'b011011, 1'b0);
        settle();
        $display("divu accept: start=%0b", md_start);
        chk("divu_start", 32'(md_start), 32'd1);
        next_cycle();
        drive(1'b1, 2'b10, 6'b100000, 1'b0);
        settle();
        $display("divu T+1 add: stall=%0b", stall);
        chk("divu_add_stall", 32'(stall), 32'd0);
        chk("divu_add_func", 32'(alu_function), 32'h2);
        next_cycle();
        drive(1'b0, 2'b00, 6'b000000, 1'b0);
        settle();
        chk("divu_T2_busy", 32'(busy), 32'd1);
        next_cycle();
        for (int k = 3; k <= 34; k++) begin
            drive(1'b1, 2'b10, 6'b010010, 1'b0);
            settle();
            $display("divu T+%0d mflo: stall=%0b busy=%0b hilo_we=%0b", k, stall, busy, hilo_we);
            chk($sformatf("divu_stall_T%0d", k), 32'(stall), 32'(k <= 33));
            chk($sformatf("divu_hilo_T%0d", k), 32'(hilo_we), 32'(k == 33));
            chk($sformatf("divu_busy_T%0d", k), 32'(busy), 32'(k <= 33));
            if (k == 3) begin
                chk("divu_md_div", 32'(md_div), 32'd1);
                chk("divu_md_signed", 32'(md_signed), 32'd0);
                chk("divu_mflo_func", 32'(alu_function), 32'hb);
            end
            next_cycle();
        end

        // DIV by zero: dropped, one-cycle div_exc at T+1, no HI/LO write
        drive(1'b1, 2'b10, 6'b011010, 1'b1);
        settle();
        $display("div0: start=%0b", md_start);
        chk("div0_start", 32'(md_start), 32'd0);
        next_cycle();
        for (int k = 1; k <= 4; k++) begin
            drive(1'b0, 2'b00, 6'b000000, 1'b0);
            settle();
            $display("div0 T+%0d: div_exc=%0b busy=%0b hilo_we=%0b", k, div_exc, busy, hilo_we);
            chk($sformatf("div0_exc_T%0d", k), 32'(div_exc), 32'(k == 1));
            chk($sformatf("div0_busy_T%0d", k), 32'(busy), 32'd0);
            chk($sformatf("div0_hilo_T%0d", k), 32'(hilo_we), 32'd0);
            next_cycle();
        end

        // Reset mid-MULT at T+2, new MULT at T+4 completes at T+9
        drive(1'b1, 2'b10, 6'b011000, 1'b0);
        settle();
        chk("rabort_start", 32'(md_start), 32'd1);
        next_cycle();
        drive(1'b0, 2'b00, 6'b000000, 1'b0);
        settle();
        chk("rabort_T1_busy", 32'(busy), 32'd1);
        next_cycle();
        rst = 1'b1;
        settle();
        chk("rabort_T2_hilo", 32'(hilo_we), 32'd0);
        next_cycle();
        rst = 1'b0;
        settle();
        $display("rabort T+3: busy=%0b", busy);
        chk("rabort_T3_busy", 32'(busy), 32'd0);
        next_cycle();
        drive(1'b1, 2'b10, 6'b011000, 1'b0);
        settle();
        $display("rabort T+4 mult: start=%0b", md_start);
        chk("rabort_T4_start", 32'(md_start), 32'd1);
        next_cycle();
        for (int k = 5; k <= 10; k++) begin
            drive(1'b0, 2'b00, 6'b000000, 1'b0);
            settle();
            $display("rabort T+%0d: busy=%0b hilo_we=%0b", k, busy, hilo_we);
            chk($sformatf("rabort_hilo_T%0d", k), 32'(hilo_we), 32'(k == 9));
            chk($sformatf("rabort_busy_T%0d", k), 32'(busy), 32'(k <= 9));
            next_cycle();
        end

        // Back-to-back MULT then MULTU: second stalls through DONE, accepted at T+6
        drive(1'b1, 2'b10, 6'b011000, 1'b0);
        settle();
        chk("b2b_first_start", 32'(md_start), 32'd1);
        next_cycle();
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 2'b10, 6'b011001, 1'b0);
            settle();
            $display("b2b T+%0d multu: stall=%0b start=%0b hilo_we=%0b", k, stall, md_start, hilo_we);
            chk($sformatf("b2b_stall_T%0d", k), 32'(stall), 32'(k <= 5));
            chk($sformatf("b2b_start_T%0d", k), 32'(md_start), 32'(k == 6));
            chk($sformatf("b2b_hilo_T%0d", k), 32'(hilo_we), 32'(k == 5));
            next_cycle();
        end
        for (int k = 7; k <= 12; k++) begin
            drive(1'b0, 2'b00, 6'b000000, 1'b0);
            settle();
            $display("b2b T+%0d: busy=%0b hilo_we=%0b", k, busy, hilo_we);
            if (k == 7) begin
                chk("b2b_md_signed", 32'(md_signed), 32'd0);
                chk("b2b_md_div", 32'(md_div), 32'd0);
            end
            chk($sformatf("b2b2_hilo_T%0d", k), 32'(hilo_we), 32'(k == 11));
            chk($sformatf("b2b2_busy_T%0d", k), 32'(busy), 32'(k <= 11));
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exec_md_control.md
Name: exec_md_control

Overview:
- Execute-stage control for the next-generation MIPS32 core.
- Performs the existing ALU function decode from alu_op/funct, extended with MFHI/MFLO selects.
- Adds a sequencer for iterative MULT/MULTU/DIV/DIVU, with configurable latencies.
- Drives start/op strobes to the multiply-divide datapath, the HI/LO write enable and a pipeline stall for HI/LO hazards.

Parameters:
- MUL_LAT, 4, multiply iteration cycles (>=1)
- DIV_LAT, 32, divide iteration cycles (>=1)
- CNT_W, $clog2(max(MUL_LAT,DIV_LAT)+1), iteration counter width (derived localparam, not overridden)

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- valid  input  1  instruction in execute is valid this cycle
- alu_op  input  2  00 add (LW/SW/ADDI), 01 subtract (BEQ/SUBI), 10 R-type, 11 reserved
- funct  input  6  R-type function field
- div_zero  input  1  divisor operand == 0, sampled only at divide accept
- alu_function  output  4  ALU operation select (combinational)
- md_start  output  1  one-cycle pulse: multiply-divide datapath loads operands
- md_div  output  1  0 multiply, 1 divide; registered at accept, held until return to IDLE
- md_signed  output  1  1 for MULT/DIV, 0 for MULTU/DIVU; registered at accept
- hilo_we  output  1  one-cycle HI/LO write enable
- div_exc  output  1  one-cycle pulse: divide by zero, op dropped
- stall  output  1  hold the PC and IF/ID stages this cycle (combinational)
- busy  output  1  sequencer not IDLE

Behaviour:
- Decode (combinational, independent of state):
  - alu_op 00 -> 0010; alu_op 01 -> 0110; alu_op 11 -> 1111.
  - alu_op 10 by funct:
    - 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001
    - 100011 -> 0011, 100110 -> 0100, 101010 -> 0111
    - 000111 -> 0101, 000110 -> 1000, 101100 -> 1001
    - 010000 MFHI -> 1010, 010010 MFLO -> 1011
    - 011000..011011 (mult/div) -> 1111
    - any other funct -> 1111
- Classification: is_md = alu_op==10 && funct in 0110xx; is_hilo_rd = alu_op==10 && funct in {010000, 010010}.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, valid && is_md && !(divide && div_zero):
    - md_start=1 this cycle (combinational accept).
    - Register md_div=funct[1] and md_signed=~funct[0].
    - Load cnt = (md_div ? DIV_LAT : MUL_LAT) - 1; go to BUSY.
  - IDLE, valid && divide && div_zero:
    - No md_start; stay in IDLE.
    - div_exc=1 in the next cycle (registered); HI/LO untouched.
  - BUSY: if cnt==0, go to DONE; else decrement cnt.
  - DONE: hilo_we=1 for exactly this cycle; go to IDLE.
- Latency: accept at cycle T -> BUSY for cycles T+1..T+LAT -> hilo_we at T+LAT+1 -> IDLE at T+LAT+2.
- stall = valid && (is_md || is_hilo_rd) && state != IDLE.
  - The accepting instruction itself never stalls; it retires and the result lands later.
  - MFHI/MFLO in the DONE cycle stalls one cycle, then reads the updated HI/LO.
  - Non-HI/LO instructions never stall, including while BUSY.
- busy = state != IDLE.
- Reset (synchronous, highest priority, also when asserted mid-BUSY or mid-DONE):
  - state=IDLE, cnt=0, md_div=0, md_signed=0, div_exc=0.
  - md_start=0 and hilo_we=0 in the reset cycle; the aborted operation never produces hilo_we.
- alu_op 11 or an undefined funct: alu_function=1111, no sequencer action, no stall.
- valid=0: no accept and no stall, regardless of alu_op/funct.

Decomposition:
- Shared package exec_pkg, holding:
  - alu_op codes;
  - funct constants, including MFHI/MFLO/MULT/MULTU/DIV/DIVU;
  - 4-bit alu_function codes, including 1010/1011;
  - FSM state enum.
- The current ALU control decode is rewritten to import the same package.
- One sub-module, alu_func_decode: the pure combinational alu_op/funct -> alu_function, is_md, is_hilo_rd decode, reused by the single-cycle core.
- The sequencer FSM and counter stay in exec_md_control.

Test Plan:
- Decode sweep: alu_op=10 over all 64 functs, plus alu_op 00/01/11 -> matches the table (e.g. 101010 -> 0111, 010010 -> 1011, 111111 -> 1111); stall=0 and md_start=0 throughout.
- MULT with MUL_LAT=4: valid, funct=011000 at T -> md_start=1 at T with md_signed=1 and md_div=0 registered; busy T+1..T+5; hilo_we only at T+5.
- DIVU (DIV_LAT=32) followed by MFLO at T+3: stall=1 from T+3 through T+33 (DONE); MFLO proceeds at T+34; an ADD issued at T+1 has stall=0.
- DIV with div_zero=1 -> no md_start, busy=0, div_exc=1 for one cycle at T+1, hilo_we never asserted.
- reset=1 at T+2 during MULT -> busy=0 at T+3, no hilo_we ever for that op; a new MULT at T+4 is accepted normally.
- Back-to-back MULT then MULTU: the second stalls through the DONE cycle, is accepted in the following IDLE cycle with md_signed=0, and yields a second hilo_we exactly MUL_LAT+1 cycles after its accept.
